// File: rtl/l2_port_arbiter_pkg.sv
// Shared cache-port types: line/address widths, arbiter state encoding, latched request.
// No logic here, so it has no latency and no backpressure.
package cache_pkg;

    localparam int ADDR_W = 30;
    localparam int LINE_W = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
    } req_buf_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    // On a tie, the side that did not win last time goes next.
    function automatic logic pick_d(input logic i_req, input logic d_req, input logic last_grant);
        return d_req && (!i_req || (last_grant == GRANT_I));
    endfunction

endpackage

// File: rtl/l2_port_arbiter_if.sv
// Bundle of the I-cache, D-cache and downstream memory port signals.
// slave = arbiter view; master = the caches and the memory around it.
interface l2_port_arbiter_if #(
    parameter int ADDR_W = cache_pkg::ADDR_W,
    parameter int LINE_W = cache_pkg::LINE_W
);
    logic              i_mem_read;
    logic [ADDR_W-1:0] i_mem_addr;
    logic [LINE_W-1:0] i_mem_rdata;
    logic              i_mem_ready;

    logic              d_mem_read;
    logic              d_mem_write;
    logic [ADDR_W-1:0] d_mem_addr;
    logic [LINE_W-1:0] d_mem_wdata;
    logic [LINE_W-1:0] d_mem_rdata;
    logic              d_mem_ready;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  i_mem_read, i_mem_addr,
        input  d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata,
        input  mem_rdata, mem_ready,
        output i_mem_rdata, i_mem_ready,
        output d_mem_rdata, d_mem_ready,
        output mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output i_mem_read, i_mem_addr,
        output d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata,
        output mem_rdata, mem_ready,
        input  i_mem_rdata, i_mem_ready,
        input  d_mem_rdata, d_mem_ready,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/l2_port_arbiter.sv
// Round-robin share of one L2 line port between I-cache and D-cache; request at t -> mem_* at t+1.
// A requester waits until granted; downstream stalls by withholding mem_ready; DONE masks trailing requests.
module l2_port_arbiter #(
    parameter int ADDR_W  = cache_pkg::ADDR_W,
    parameter int LINE_W  = cache_pkg::LINE_W,
    parameter bit D_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    l2_port_arbiter_if.slave bus
);
    import cache_pkg::*;

    arb_state_t        state;
    logic              last_grant;
    req_buf_t          req_q;
    logic [LINE_W-1:0] rdata_buf;

    logic              i_req;
    logic              d_req;
    logic              grant_d;
    logic              done_i;
    logic              done_d;
    logic [LINE_W-1:0] line_in;
    logic [ADDR_W-1:0] i_addr;
    logic [ADDR_W-1:0] d_addr;

    assign i_req   = bus.i_mem_read;
    assign d_req   = bus.d_mem_read | bus.d_mem_write;
    assign grant_d = pick_d(i_req, d_req, last_grant);
    assign line_in = bus.mem_rdata;
    assign i_addr  = bus.i_mem_addr;
    assign d_addr  = bus.d_mem_addr;

    assign done_i = (state == BUSY_I) && bus.mem_ready;
    assign done_d = (state == BUSY_D) && bus.mem_ready;

    // rd/wr are cleared on completion, so the buffer alone drives the port idle in DONE/IDLE.
    assign bus.mem_read  = req_q.rd;
    assign bus.mem_write = req_q.wr;
    assign bus.mem_addr  = req_q.addr;
    assign bus.mem_wdata = req_q.wdata;

    assign bus.i_mem_ready = done_i;
    assign bus.d_mem_ready = done_d;
    assign bus.i_mem_rdata = done_i ? line_in : rdata_buf;
    assign bus.d_mem_rdata = done_d ? line_in : rdata_buf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= D_FIRST ? GRANT_I : GRANT_D;
            req_q      <= '0;
            rdata_buf  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        req_q.rd    <= bus.d_mem_read;
                        req_q.wr    <= bus.d_mem_write;
                        req_q.addr  <= d_addr;
                        req_q.wdata <= bus.d_mem_wdata;
                        last_grant  <= GRANT_D;
                        state       <= BUSY_D;
                    end else if (i_req) begin
                        req_q.rd    <= 1'b1;
                        req_q.wr    <= 1'b0;
                        req_q.addr  <= i_addr;
                        req_q.wdata <= '0;
                        last_grant  <= GRANT_I;
                        state       <= BUSY_I;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (bus.mem_ready) begin
                        if (req_q.rd) begin
                            rdata_buf <= line_in;
                        end
                        req_q.rd <= 1'b0;
                        req_q.wr <= 1'b0;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Bench for l2_port_arbiter: vector table of single transactions plus hand-written tie, masking and reset sequences.
module tb_l2_port_arbiter;
    import cache_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    l2_port_arbiter_if bus ();

    l2_port_arbiter #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W),
        .D_FIRST(1'b1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        bit                side;        // 1 = D-cache, 0 = I-cache
        bit                rd;
        bit                wr;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
        int                lat;         // cycles in BUSY including the ready cycle
        logic [LINE_W-1:0] rdata;
        bit                drop;        // change/drop D inputs after the grant
        bit                ready_hold;  // keep mem_ready high into DONE
        bit                exp_rd;
        bit                exp_wr;
        logic [LINE_W-1:0] exp_wdata;
    } vec_t;

    typedef struct {
        bit                side;
        logic [LINE_W-1:0] rdata;
    } sb_t;

    localparam int NV = 6;
    vec_t vecs [NV];
    sb_t  sb [$];

    int n_tests = 0;
    int n_fail  = 0;
    logic [LINE_W-1:0] exp_buf = '0;

    task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Every completion pulse must match the oldest outstanding grant.
    always @(negedge clk) begin
        if (rst_n && (bus.i_mem_ready || bus.d_mem_ready)) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_ready: got i=%b d=%b expected none", bus.i_mem_ready, bus.d_mem_ready);
            end else begin
                sb_t e;
                e = sb.pop_front();
                if ({bus.d_mem_ready, bus.i_mem_ready} !== (e.side ? 2'b10 : 2'b01)) begin
                    n_fail++;
                    $display("FAIL sb_ready_side: got d=%b i=%b expected side %0d", bus.d_mem_ready, bus.i_mem_ready, e.side);
                end
                chk("sb_rdata", e.side ? bus.d_mem_rdata : bus.i_mem_rdata, e.rdata);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_req();
        bus.i_mem_read  = 1'b0;
        bus.d_mem_read  = 1'b0;
        bus.d_mem_write = 1'b0;
    endtask

    task automatic drive_req(input vec_t v);
        if (v.side) begin
            bus.d_mem_read  = v.rd;
            bus.d_mem_write = v.wr;
            bus.d_mem_addr  = v.addr;
            bus.d_mem_wdata = v.wdata;
        end else begin
            bus.i_mem_read  = 1'b1;
            bus.i_mem_addr  = v.addr;
            bus.d_mem_wdata = v.wdata;
        end
    endtask

    // Called #1 after a rising edge with the DUT in IDLE and the request already driven.
    task automatic serve(input vec_t v);
        sb.push_back('{side: v.side, rdata: v.rdata});
        @(negedge clk);
        chk("idle_port_quiet", {bus.mem_read, bus.mem_write}, 2'b00);
        @(posedge clk); #1;
        if (v.drop) begin
            bus.d_mem_addr  = 30'h7;
            bus.d_mem_read  = 1'b0;
            bus.d_mem_write = 1'b0;
        end
        for (int c = 1; c <= v.lat; c++) begin
            if (c == v.lat) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = v.rdata;
            end else begin
                bus.mem_rdata = ~v.rdata;
            end
            @(negedge clk);
            chk("busy_mem_read", bus.mem_read, v.exp_rd);
            chk("busy_mem_write", bus.mem_write, v.exp_wr);
            chk("busy_mem_addr", bus.mem_addr, v.addr);
            chk("busy_mem_wdata", bus.mem_wdata, v.exp_wdata);
            if (c < v.lat) begin
                chk("busy_no_ready", {bus.d_mem_ready, bus.i_mem_ready}, 2'b00);
            end else begin
                chk("bypass_rdata", v.side ? bus.d_mem_rdata : bus.i_mem_rdata, v.rdata);
                chk("other_rdata_buf", v.side ? bus.i_mem_rdata : bus.d_mem_rdata, exp_buf);
            end
            @(posedge clk); #1;
        end
        if (!v.ready_hold) bus.mem_ready = 1'b0;
        if (v.rd) exp_buf = v.rdata;
        @(negedge clk);
        chk("done_port_quiet", {bus.mem_read, bus.mem_write}, 2'b00);
        chk("done_no_ready", {bus.d_mem_ready, bus.i_mem_ready}, 2'b00);
        chk("done_i_rdata", bus.i_mem_rdata, exp_buf);
        chk("done_d_rdata", bus.d_mem_rdata, exp_buf);
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
    endtask

    task automatic tie_run();
        vec_t vi;
        vec_t vd;
        vi = '{side: 1'b0, rd: 1'b1, wr: 1'b0, addr: 30'h11, wdata: {4{32'h0}}, lat: 1,
               rdata: {4{32'h11111111}}, drop: 1'b0, ready_hold: 1'b0, exp_rd: 1'b1, exp_wr: 1'b0, exp_wdata: 128'h0};
        vd = '{side: 1'b1, rd: 1'b1, wr: 1'b0, addr: 30'h22, wdata: {4{32'h2222ABCD}}, lat: 2,
               rdata: {4{32'h22222222}}, drop: 1'b0, ready_hold: 1'b0, exp_rd: 1'b1, exp_wr: 1'b0, exp_wdata: {4{32'h2222ABCD}}};
        drive_req(vi);
        drive_req(vd);
        serve(vd);
        serve(vi);
        serve(vd);
        serve(vi);
        clear_req();
    endtask

    initial begin
        vecs[0] = '{side: 1'b0, rd: 1'b1, wr: 1'b0, addr: 30'h40, wdata: {4{32'hDEADBEEF}}, lat: 3,
                    rdata: {16{8'hA5}}, drop: 1'b0, ready_hold: 1'b0, exp_rd: 1'b1, exp_wr: 1'b0, exp_wdata: 128'h0};
        vecs[1] = '{side: 1'b1, rd: 1'b0, wr: 1'b1, addr: 30'h100, wdata: {8{16'h1234}}, lat: 2,
                    rdata: {4{32'h0BAD0BAD}}, drop: 1'b0, ready_hold: 1'b1, exp_rd: 1'b0, exp_wr: 1'b1, exp_wdata: {8{16'h1234}}};
        vecs[2] = '{side: 1'b1, rd: 1'b1, wr: 1'b0, addr: 30'h101, wdata: 128'h0, lat: 1,
                    rdata: {8{16'h5A5A}}, drop: 1'b0, ready_hold: 1'b0, exp_rd: 1'b1, exp_wr: 1'b0, exp_wdata: 128'h0};
        vecs[3] = '{side: 1'b1, rd: 1'b1, wr: 1'b1, addr: 30'h200, wdata: {4{32'hCAFEF00D}}, lat: 4,
                    rdata: {4{32'h13579BDF}}, drop: 1'b0, ready_hold: 1'b0, exp_rd: 1'b1, exp_wr: 1'b1, exp_wdata: {4{32'hCAFEF00D}}};
        vecs[4] = '{side: 1'b0, rd: 1'b1, wr: 1'b0, addr: 30'h3FFFFFFF, wdata: {4{32'hFFFF0000}}, lat: 1,
                    rdata: {4{32'hFFFFFFFF}}, drop: 1'b0, ready_hold: 1'b0, exp_rd: 1'b1, exp_wr: 1'b0, exp_wdata: 128'h0};
        vecs[5] = '{side: 1'b1, rd: 1'b1, wr: 1'b0, addr: 30'h2AAAAAAA, wdata: 128'h0, lat: 3,
                    rdata: {4{32'h00C0FFEE}}, drop: 1'b1, ready_hold: 1'b0, exp_rd: 1'b1, exp_wr: 1'b0, exp_wdata: 128'h0};

        clear_req();
        bus.i_mem_addr  = '0;
        bus.d_mem_addr  = '0;
        bus.d_mem_wdata = '0;
        bus.mem_rdata   = '0;
        bus.mem_ready   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_port", {bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata}, '0);
        chk("rst_ready", {bus.i_mem_ready, bus.d_mem_ready}, 2'b00);
        chk("rst_rdata", bus.i_mem_rdata | bus.d_mem_rdata, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // D wins the first tie after reset, then strict alternation.
        tie_run();

        for (int k = 0; k < NV; k++) begin
            drive_req(vecs[k]);
            serve(vecs[k]);
            clear_req();
        end

        // mem_ready while IDLE: no pulse, no state change.
        bus.mem_ready = 1'b1;
        @(negedge clk);
        chk("idle_ready_ignored", {bus.d_mem_ready, bus.i_mem_ready, bus.mem_read, bus.mem_write}, 4'b0);
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        chk("idle_stays_idle", {bus.mem_read, bus.mem_write}, 2'b00);
        @(posedge clk); #1;

        // Trailing request held through DONE is masked; re-grant only if still held in IDLE.
        drive_req(vecs[0]);
        serve(vecs[0]);
        serve(vecs[0]);
        clear_req();
        @(negedge clk);
        chk("trail_idle_quiet", bus.mem_read, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("trail_no_regrant", bus.mem_read, 1'b0);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of BUSY_I.
        bus.i_mem_read = 1'b1;
        bus.i_mem_addr = 30'h55;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_busy", {bus.mem_read, bus.mem_addr}, {1'b1, 30'h55});
        #1;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = {4{32'h99999999}};
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mem_port", {bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata}, '0);
        chk("mid_rst_ready", {bus.i_mem_ready, bus.d_mem_ready}, 2'b00);
        chk("mid_rst_rdata", bus.i_mem_rdata | bus.d_mem_rdata, '0);
        exp_buf = '0;
        clear_req();
        bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tie_run();

        repeat (3) @(posedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
